// File: rtl/pll_drp_sequencer_pkg.sv
// rtl/pll_drp_sequencer_pkg.sv - shared types and helpers for the pll DRP sequencer
package pll_drp_sequencer_pkg;

    localparam int DRP_AW  = 7;
    localparam int DRP_DW  = 16;
    localparam int ENTRY_W = DRP_AW + 2 * DRP_DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RELEASE,
        S_LOCK_WAIT
    } state_e;

    // Field order matches the CFG_DATA layout {addr[38:32], keep_mask[31:16], data[15:0]}.
    typedef struct packed {
        logic [DRP_AW-1:0] addr;
        logic [DRP_DW-1:0] mask;
        logic [DRP_DW-1:0] data;
    } entry_t;

    function automatic logic [DRP_DW-1:0] rmw_merge(input logic [DRP_DW-1:0] rd_val,
                                                    input logic [DRP_DW-1:0] keep_mask,
                                                    input logic [DRP_DW-1:0] new_val);
        return (rd_val & keep_mask) | (new_val & ~keep_mask);
    endfunction

endpackage

// File: rtl/pll_drp_table.sv
// rtl/pll_drp_table.sv - configuration entry storage, synchronous write, asynchronous read
module pll_drp_table #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 39
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pll_drp_sequencer.sv
// rtl/pll_drp_sequencer.sv - applies a stored register set to a pll through read-modify-write DRP accesses
module pll_drp_sequencer
    import pll_drp_sequencer_pkg::*;
#(
    parameter int NUM_CFG      = 2,
    parameter int NUM_REGS     = 8,
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic                 DCLK,
    input  logic                 RST_N,
    input  logic                 CFG_WE,
    input  logic [((NUM_CFG*NUM_REGS > 1) ? $clog2(NUM_CFG*NUM_REGS) : 1)-1:0] CFG_ADDR,
    input  logic [ENTRY_W-1:0]   CFG_DATA,
    input  logic                 START,
    input  logic [((NUM_CFG > 1) ? $clog2(NUM_CFG) : 1)-1:0] CFG_SEL,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic                 PLL_RST,
    output logic [DRP_AW-1:0]    DADDR,
    output logic                 DEN,
    output logic                 DWE,
    output logic [DRP_DW-1:0]    DI,
    input  logic [DRP_DW-1:0]    DO,
    input  logic                 DRDY,
    input  logic                 LOCKED
);

    localparam int TBL_DEPTH = NUM_CFG * NUM_REGS;
    localparam int AW        = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;
    localparam int SW        = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int IW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_MAX_A = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int CW        = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                pll_rst_q, pll_rst_d;
    logic                den_q, den_d;
    logic                dwe_q, dwe_d;
    logic [DRP_AW-1:0]   daddr_q, daddr_d;
    logic [DRP_DW-1:0]   di_q, di_d;

    logic                addr_ok;
    logic                sel_ok;
    logic                tbl_we;
    logic                last_idx;
    logic [IW-1:0]       rd_idx;
    logic [AW-1:0]       rd_addr;
    logic [ENTRY_W-1:0]  tbl_rdata;
    entry_t              rd_entry;

    assign addr_ok  = ({1'b0, CFG_ADDR} < (AW+1)'(TBL_DEPTH));
    assign sel_ok   = ({1'b0, CFG_SEL} < (SW+1)'(NUM_CFG));
    assign tbl_we   = CFG_WE && (state_q == S_IDLE) && addr_ok;
    assign last_idx = (idx_q == IW'(NUM_REGS - 1));

    // While waiting on a write the table already looks ahead so DADDR is ready when RD begins.
    assign rd_idx   = ((state_q == S_WR_WAIT) && !last_idx) ? idx_q + IW'(1) : idx_q;
    assign rd_addr  = AW'(sel_q) * AW'(NUM_REGS) + AW'(rd_idx);
    assign rd_entry = entry_t'(tbl_rdata);

    pll_drp_table #(
        .DEPTH (TBL_DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_table (
        .clk   (DCLK),
        .we    (tbl_we),
        .waddr (CFG_ADDR),
        .wdata (CFG_DATA),
        .raddr (rd_addr),
        .rdata (tbl_rdata)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        daddr_d = daddr_q;
        di_d    = di_q;

        case (state_q)
            S_IDLE: begin
                if (START && sel_ok) begin
                    sel_d   = CFG_SEL;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(RST_HOLD - 1)) begin
                    state_d = S_RD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (DRDY) begin
                    di_d    = rmw_merge(DO, rd_entry.mask, rd_entry.data);
                    state_d = S_WR;
                end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR: begin
                cnt_d   = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (DRDY) begin
                    if (last_idx) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_RD;
                    end
                end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE: begin
                cnt_d   = '0;
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                if (LOCKED) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        den_d     = (state_d == S_RD) || (state_d == S_WR);
        dwe_d     = (state_d == S_WR);
        busy_d    = (state_d != S_IDLE);
        pll_rst_d = (state_d == S_HOLD) || (state_d == S_RD) || (state_d == S_RD_WAIT) ||
                    (state_d == S_WR) || (state_d == S_WR_WAIT);
        if ((state_d == S_RD) && (state_q != S_RD)) begin
            daddr_d = rd_entry.addr;
        end
    end

    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pll_rst_q <= 1'b0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            pll_rst_q <= pll_rst_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign PLL_RST = pll_rst_q;
    assign DEN     = den_q;
    assign DWE     = dwe_q;
    assign DADDR   = daddr_q;
    assign DI      = di_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// tb/tb_pll_drp_sequencer.sv - directed bench for pll_drp_sequencer with a behavioural DRP slave
`timescale 1ns/1ps
module tb_pll_drp_sequencer;

    logic        dclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [38:0] cfg_data = '0;
    logic        start = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic        busy, done, err, pll_rst, den, dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] drp_do = '0;
    logic        drdy_m = 1'b0;
    logic        drdy_x = 1'b0;
    logic        drdy;
    logic        lock_en = 1'b1;
    logic        locked;

    assign drdy   = drdy_m | drdy_x;
    assign locked = lock_en & ~pll_rst;

    int checks = 0;
    int errors = 0;

    always #5 dclk = ~dclk;

    pll_drp_sequencer #(
        .NUM_CFG      (3),
        .NUM_REGS     (8),
        .RST_HOLD     (4),
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (200)
    ) dut (
        .DCLK (dclk), .RST_N (rst_n), .CFG_WE (cfg_we), .CFG_ADDR (cfg_addr),
        .CFG_DATA (cfg_data), .START (start), .CFG_SEL (cfg_sel),
        .BUSY (busy), .DONE (done), .ERR (err), .PLL_RST (pll_rst),
        .DADDR (daddr), .DEN (den), .DWE (dwe), .DI (di),
        .DO (drp_do), .DRDY (drdy), .LOCKED (locked)
    );

    logic [6:0]  c0_addr [8] = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h14, 7'h7F};
    logic [15:0] c0_mask [8] = '{16'h1000, 16'h0000, 16'hFFFF, 16'hFF00, 16'h00FF, 16'hF0F0, 16'h8000, 16'h0001};
    logic [15:0] c0_data [8] = '{16'h0041, 16'hABCD, 16'h1234, 16'h00C3, 16'h7700, 16'h0F0F, 16'h0001, 16'hFFFE};
    logic [15:0] c0_pre  [8] = '{16'h1145, 16'hFFFF, 16'h5A5A, 16'h12FF, 16'hAB34, 16'h3C3C, 16'h8002, 16'h0001};
    logic [15:0] c0_exp  [8] = '{16'h1041, 16'hABCD, 16'h5A5A, 16'h12C3, 16'h7734, 16'h3F3F, 16'h8001, 16'hFFFF};

    // Behavioural DRP slave: DRDY arrives lat cycles after the DEN cycle (lat=1 is zero-wait).
    logic [15:0] regs [128];
    int          lat = 1;
    bit          no_resp = 1'b0;
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    logic [6:0]  m_addr = '0;
    bit          m_we = 1'b0;
    logic [15:0] m_di = '0;

    always @(posedge dclk) begin
        drdy_m <= 1'b0;
        if (m_pend) begin
            if (m_cnt == 0) begin
                drdy_m <= 1'b1;
                drp_do <= regs[m_addr];
                if (m_we) regs[m_addr] = m_di;
                m_pend = 1'b0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        if (den && !no_resp) begin
            m_addr = daddr;
            m_we   = dwe;
            m_di   = di;
            if (lat <= 1) begin
                drdy_m <= 1'b1;
                drp_do <= regs[m_addr];
                if (m_we) regs[m_addr] = m_di;
            end else begin
                m_pend = 1'b1;
                m_cnt  = lat - 2;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [6:0]  q_addr [$];
    bit          q_we   [$];
    logic [15:0] q_di   [$];
    bit          q_rst  [$];
    bit          outstanding = 1'b0;
    bit          inject = 1'b0;
    int          done_cnt = 0;

    always @(negedge dclk) begin
        if (den) begin
            chk("den_while_pending", 32'(outstanding), 32'd0);
            q_addr.push_back(daddr);
            q_we.push_back(dwe);
            q_di.push_back(di);
            q_rst.push_back(pll_rst);
            outstanding = 1'b1;
        end else if (drdy_m) begin
            outstanding = 1'b0;
        end
        if (done) done_cnt++;
        drdy_x = inject && den && !dwe;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge dclk);
    endtask

    task automatic load(input int a, input logic [6:0] ad, input logic [15:0] m, input logic [15:0] d);
        @(negedge dclk);
        cfg_we   = 1'b1;
        cfg_addr = 5'(a);
        cfg_data = {ad, m, d};
        @(negedge dclk);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        @(negedge dclk);
        start   = 1'b1;
        cfg_sel = sel;
        @(negedge dclk);
        start   = 1'b0;
    endtask

    task automatic preset();
        for (int i = 0; i < 8; i++) begin
            regs[c0_addr[i]] = c0_pre[i];
            regs[7'(32 + i)] = 16'hFFFF;
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_we.delete();
        q_di.delete();
        q_rst.delete();
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge dclk);
            n++;
        end
    endtask

    initial begin
        int n;
        int dc;
        for (int i = 0; i < 128; i++) regs[i] = '0;

        // Reset state
        tick(3);
        chk("rst_outputs", 32'({busy, done, err, pll_rst, den, dwe, daddr, di}), 32'd0);
        @(negedge dclk);
        rst_n = 1'b1;
        tick(1);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            load(i, c0_addr[i], c0_mask[i], c0_data[i]);
            load(8 + i, 7'(32 + i), 16'h0000, 16'(256 + i));
            load(16 + i, 7'(48 + i), 16'hFFFF, 16'h0000);
        end
        preset();

        // T1: zero-wait DRP, minimum latency, read-modify-write values
        clear_log();
        lat = 1;
        @(negedge dclk);
        start   = 1'b1;
        cfg_sel = 2'd0;
        n = 0;
        do begin
            @(negedge dclk);
            start = 1'b0;
            n++;
            if (n == 2) chk("t1_busy_pll_rst", 32'({busy, pll_rst}), 32'h3);
        end while (!done && n < 100);
        chk("t1_latency", 32'(n), 32'd39);
        tick(1);
        chk("t1_done_pulse", 32'({done, busy, err}), 32'd0);
        chk("t1_txn_count", 32'(q_we.size()), 32'd16);
        if (q_we.size() >= 16) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t1_rd%0d", i), 32'({q_we[2*i], q_addr[2*i], q_rst[2*i]}), 32'({1'b0, c0_addr[i], 1'b1}));
                chk($sformatf("t1_wr%0d", i), 32'({q_we[2*i+1], q_addr[2*i+1], q_rst[2*i+1]}), 32'({1'b1, c0_addr[i], 1'b1}));
                chk($sformatf("t1_di%0d", i), 32'(q_di[2*i+1]), 32'(c0_exp[i]));
            end
        end
        chk("t1_reg08", 32'(regs[7'h08]), 32'h1041);

        // T2: DRDY latency 3, spurious DRDY in read DEN cycle, table write while busy ignored
        clear_log();
        lat    = 3;
        inject = 1'b1;
        @(negedge dclk);
        start   = 1'b1;
        cfg_sel = 2'd1;
        n = 0;
        do begin
            @(negedge dclk);
            start    = 1'b0;
            n++;
            cfg_we   = (n == 10);
            cfg_addr = 5'd15;
            cfg_data = {7'h55, 16'h0000, 16'hDEAD};
        end while (!done && n < 400);
        cfg_we = 1'b0;
        inject = 1'b0;
        chk("t2_latency", 32'(n), 32'd71);
        chk("t2_txn_count", 32'(q_we.size()), 32'd16);
        if (q_we.size() >= 16) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t2_rd%0d", i), 32'({q_we[2*i], q_addr[2*i]}), 32'({1'b0, 7'(32 + i)}));
                chk($sformatf("t2_wr%0d", i), 32'({q_we[2*i+1], q_addr[2*i+1], q_di[2*i+1]}), 32'({1'b1, 7'(32 + i), 16'(256 + i)}));
            end
        end
        chk("t2_reg27", 32'(regs[7'h27]), 32'h0107);

        // T3: DRDY timeout, invalid select, ERR cleared by next START
        tick(2);
        dc = done_cnt;
        no_resp = 1'b1;
        pulse_start(2'd0);
        n = 0;
        while (!den && n < 50) begin
            @(negedge dclk);
            n++;
        end
        chk("t3_first_den", 32'({den, dwe}), 32'h2);
        n = 0;
        do begin
            @(negedge dclk);
            n++;
        end while (!err && n < 200);
        chk("t3_drdy_tmo", 32'(n), 32'd65);
        chk("t3_after_err", 32'({err, busy, pll_rst, den}), 32'h8);
        chk("t3_no_done", 32'(done_cnt), 32'(dc));
        outstanding = 1'b0;
        no_resp = 1'b0;
        pulse_start(2'd3);
        tick(2);
        chk("t3_bad_sel_ignored", 32'({busy, err}), 32'h1);
        lat = 1;
        preset();
        pulse_start(2'd0);
        chk("t3_err_cleared", 32'({busy, err}), 32'h2);
        wait_done(100, n);
        chk("t3_rerun_done", 32'(done), 32'd1);

        // T4: lock timeout with START pulsed while busy
        tick(2);
        dc = done_cnt;
        lock_en = 1'b0;
        pulse_start(2'd1);
        n = 0;
        while (!(busy && !pll_rst) && n < 200) begin
            @(negedge dclk);
            n++;
        end
        chk("t4_release", 32'({busy, pll_rst}), 32'h2);
        n = 0;
        do begin
            @(negedge dclk);
            n++;
            start   = (n == 50);
            cfg_sel = 2'd0;
        end while (!err && n < 400);
        start = 1'b0;
        chk("t4_lock_tmo", 32'(n), 32'd201);
        chk("t4_after_err", 32'({err, busy, pll_rst}), 32'h4);
        chk("t4_no_done", 32'(done_cnt), 32'(dc));
        lock_en = 1'b1;

        // T5: asynchronous reset during WR_WAIT, then a clean rerun
        lat = 3;
        clear_log();
        pulse_start(2'd1);
        n = 0;
        while (!(den && dwe) && n < 100) begin
            @(negedge dclk);
            n++;
        end
        chk("t5_wr_seen", 32'({den, dwe, pll_rst}), 32'h7);
        @(negedge dclk);
        #1 rst_n = 1'b0;
        #1 chk("t5_reset_outputs", 32'({busy, done, err, pll_rst, den, dwe, daddr, di}), 32'd0);
        tick(4);
        rst_n = 1'b1;
        outstanding = 1'b0;
        clear_log();
        lat = 1;
        pulse_start(2'd1);
        wait_done(100, n);
        chk("t5_rerun_done", 32'(done), 32'd1);
        chk("t5_txn_count", 32'(q_we.size()), 32'd16);
        tick(2);
        chk("t5_final_idle", 32'({busy, err, pll_rst}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
